// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an off-chip controller and the spi_reg_bank target.
interface spi_reg_bank_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;

  modport master (output sclk, output copi, output ncs, input cipo);
  modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target that decodes 16-bit write frames into the five PWM control registers.
// Define SPI_READBACK_EN to return register data on cipo during read frames.
module spi_reg_bank #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic           clk,
  input  logic           rst,
  spi_reg_bank_if.slave  spi,
  output logic [7:0]     en_reg_out_7_0,
  output logic [7:0]     en_reg_out_15_8,
  output logic [7:0]     en_reg_pwm_7_0,
  output logic [7:0]     en_reg_pwm_15_8,
  output logic [7:0]     pwm_duty_cycle,
  output logic           wr_strobe,
  output logic           err_frame
);
  localparam int unsigned NUM_REGS   = 5;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned SETTLE_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
  logic                  r_sclk_d, r_ncs_d;
  logic [SETTLE_W-1:0]   r_settle;
  logic                  r_armed;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [7:0]            r_regs [NUM_REGS];

  logic       w_sclk_s, w_copi_s, w_ncs_s;
  logic       w_sclk_rise, w_ncs_fall, w_ncs_rise, w_wr_ok;
  logic [6:0] w_addr;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
  assign w_addr      = r_shift[14:8];
  assign w_wr_ok     = (r_cnt == CNT_FULL) && r_shift[15] &&
                       (w_addr <= 7'(MAX_ADDR)) && (w_addr < 7'(NUM_REGS));

`ifdef SPI_READBACK_EN
  logic       r_rd_active;
  logic [7:0] r_rd_data;
  logic [3:0] r_rd_cnt;
  logic       r_cipo;
  logic       w_sclk_fall;
  logic [6:0] w_rd_addr;
  logic [7:0] w_rd_sel;

  // Address is complete on the 8th rising edge: six bits already shifted plus the live copi bit.
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_rd_addr   = {r_shift[5:0], w_copi_s};
  assign w_rd_sel    = ((w_rd_addr <= 7'(MAX_ADDR)) && (w_rd_addr < 7'(NUM_REGS))) ?
                       r_regs[w_rd_addr[2:0]] : 8'h00;
  assign spi.cipo    = r_cipo;
`else
  assign spi.cipo    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b1;
      r_settle    <= SETTLE_W'(SYNC_STAGES);
      r_armed     <= 1'b0;
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      wr_strobe   <= 1'b0;
      err_frame   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
`ifdef SPI_READBACK_EN
      r_rd_active <= 1'b0;
      r_rd_data   <= '0;
      r_rd_cnt    <= '0;
      r_cipo      <= 1'b0;
`endif
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      r_sclk_d    <= w_sclk_s;
      r_ncs_d     <= w_ncs_s;
      wr_strobe   <= 1'b0;
      err_frame   <= 1'b0;

      // The reset-loaded ncs=1 must flush out before a falling edge can count as a real one.
      if (r_settle != '0) r_settle <= r_settle - 1'b1;
      if ((r_settle == '0) && w_ncs_s) r_armed <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_ncs_fall && r_armed) begin
            r_state <= SHIFT;
            r_shift <= '0;
            r_cnt   <= '0;
`ifdef SPI_READBACK_EN
            r_rd_active <= 1'b0;
            r_rd_cnt    <= '0;
            r_cipo      <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (w_ncs_rise) begin
            r_state <= COMMIT;
`ifdef SPI_READBACK_EN
            r_rd_active <= 1'b0;
            r_cipo      <= 1'b0;
`endif
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_s};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
`ifdef SPI_READBACK_EN
            if (r_cnt == CNT_W'(7)) begin
              r_rd_active <= ~r_shift[6];
              r_rd_data   <= w_rd_sel;
              r_rd_cnt    <= '0;
            end
`endif
          end
`ifdef SPI_READBACK_EN
          else if (w_sclk_fall && r_rd_active) begin
            if (r_rd_cnt < 4'd8) begin
              r_cipo    <= r_rd_data[7];
              r_rd_data <= {r_rd_data[6:0], 1'b0};
              r_rd_cnt  <= r_rd_cnt + 1'b1;
            end else begin
              r_cipo <= 1'b0;
            end
          end
`endif
        end
        COMMIT: begin
          r_state <= IDLE;
          if (w_wr_ok) begin
            r_regs[w_addr[2:0]] <= r_shift[7:0];
            wr_strobe           <= 1'b1;
          end else if (r_cnt != CNT_FULL) begin
            err_frame <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_regs[0];
  assign en_reg_out_15_8 = r_regs[1];
  assign en_reg_pwm_7_0  = r_regs[2];
  assign en_reg_pwm_15_8 = r_regs[3];
  assign pwm_duty_cycle  = r_regs[4];
endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed frames plus randomized frames against a register model.
// Readback checks are included when SPI_READBACK_EN is defined.
module tb_spi_reg_bank;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          HALF        = 4;   // clk periods per sclk phase (sclk = clk/8)

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_reg_bank_if spi_if();
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe, err_frame;

  spi_reg_bank #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (spi_if),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .err_frame       (err_frame)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int exp_strobe = 0;
  int exp_err = 0;
  logic [7:0] model [5];

  // Pulse counters; each pulse is one clk wide so a single negedge sample sees it once.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt++;
    if (err_frame === 1'b1) err_cnt++;
  end

  function automatic logic [7:0] dut_reg(input int a);
    case (a)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      4: return pwm_duty_cycle;
      default: return 8'h00;
    endcase
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference behaviour of one frame; returns the cipo bits a controller should sample.
  task automatic model_frame(input logic [15:0] f, input int nbits, output logic [31:0] exp_rx);
    int a;
    a = int'(f[14:8]);
    exp_rx = '0;
    if (nbits != 16) exp_err++;
    else if (f[15]) begin
      if (a <= 4) begin
        model[a] = f[7:0];
        exp_strobe++;
      end
    end
`ifdef SPI_READBACK_EN
    else begin
      logic [7:0] v;
      v = (a <= 4) ? model[a] : 8'h00;
      for (int k = 0; k < 8; k++) exp_rx[8+k] = v[7-k];
    end
`endif
  endtask

  // Mode-0 controller: copi set while sclk low, cipo sampled just before each rising edge.
  task automatic send_frame(input logic [15:0] f, input int nbits, input int gap,
                            input bit raise, output logic [31:0] rxo);
    rxo = '0;
    spi_if.ncs = 1'b0;
    clk_wait(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_if.copi = (i < 16) ? f[15-i] : 1'b0;
      clk_wait(HALF);
      rxo[i] = spi_if.cipo;
      spi_if.sclk = 1'b1;
      clk_wait(HALF);
      spi_if.sclk = 1'b0;
    end
    clk_wait(HALF);
    if (raise) begin
      spi_if.ncs  = 1'b1;
      spi_if.copi = 1'b0;
      clk_wait(gap);
    end
  endtask

  task automatic test_reset();
    spi_if.ncs = 1'b1; spi_if.sclk = 1'b0; spi_if.copi = 1'b0;
    rst = 1'b1;
    clk_wait(3);
    rst = 1'b0;
    for (int a = 0; a < 5; a++) model[a] = 8'h00;
    clk_wait(1);
    for (int a = 0; a < 5; a++) begin
      n_cmp++;
      if (dut_reg(a) !== model[a]) begin
        n_bad++; $display("FAIL reset_reg%0d got=%h exp=%h", a, dut_reg(a), model[a]);
      end
    end
    n_cmp++;
    if ({wr_strobe, err_frame, spi_if.cipo} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=000", {wr_strobe, err_frame, spi_if.cipo});
    end
    clk_wait(4);
  endtask

  task automatic test_writes();
    logic [15:0] frames [4] = '{16'h80F0, 16'h8480, 16'h82FF, 16'h85AA};
    logic [31:0] erx, rx;
    for (int n = 0; n < 4; n++) begin
      model_frame(frames[n], 16, erx);
      send_frame(frames[n], 16, 8, 1'b1, rx);
      for (int a = 0; a < 5; a++) begin
        n_cmp++;
        if (dut_reg(a) !== model[a]) begin
          n_bad++; $display("FAIL write_%h_reg%0d got=%h exp=%h", frames[n], a, dut_reg(a), model[a]);
        end
      end
      n_cmp++;
      if (strobe_cnt !== exp_strobe || err_cnt !== exp_err) begin
        n_bad++; $display("FAIL write_%h_pulses strobe=%0d/%0d err=%0d/%0d",
                          frames[n], strobe_cnt, exp_strobe, err_cnt, exp_err);
      end
    end
  endtask

  task automatic test_bad_length();
    int lens [3] = '{15, 17, 0};
    logic [31:0] erx, rx;
    for (int n = 0; n < 3; n++) begin
      model_frame(16'h81AA, lens[n], erx);
      send_frame(16'h81AA, lens[n], 8, 1'b1, rx);
      n_cmp++;
      if (en_reg_out_15_8 !== model[1]) begin
        n_bad++; $display("FAIL badlen%0d_reg1 got=%h exp=%h", lens[n], en_reg_out_15_8, model[1]);
      end
      n_cmp++;
      if (strobe_cnt !== exp_strobe || err_cnt !== exp_err) begin
        n_bad++; $display("FAIL badlen%0d_pulses strobe=%0d/%0d err=%0d/%0d",
                          lens[n], strobe_cnt, exp_strobe, err_cnt, exp_err);
      end
    end
  endtask

  // Register must change exactly SYNC_STAGES+2 clk after the raw ncs rise.
  task automatic test_latency();
    logic [31:0] erx, rx;
    logic [7:0] old_v, new_v;
    old_v = model[3];
    new_v = ~old_v;
    model_frame({8'h83, new_v}, 16, erx);
    send_frame({8'h83, new_v}, 16, 0, 1'b0, rx);
    spi_if.ncs = 1'b1;
    clk_wait(SYNC_STAGES + 1);
    n_cmp++;
    if (en_reg_pwm_15_8 !== old_v || wr_strobe !== 1'b0) begin
      n_bad++; $display("FAIL latency_early got=%h/%b exp=%h/0", en_reg_pwm_15_8, wr_strobe, old_v);
    end
    clk_wait(1);
    n_cmp++;
    if (en_reg_pwm_15_8 !== new_v || wr_strobe !== 1'b1) begin
      n_bad++; $display("FAIL latency_edge got=%h/%b exp=%h/1", en_reg_pwm_15_8, wr_strobe, new_v);
    end
    clk_wait(6);
  endtask

  task automatic test_back_to_back();
    logic [31:0] erx, rx;
    model_frame(16'h8011, 16, erx);
    send_frame(16'h8011, 16, SYNC_STAGES + 2, 1'b1, rx);
    model_frame(16'h8122, 16, erx);
    send_frame(16'h8122, 16, 8, 1'b1, rx);
    for (int a = 0; a < 5; a++) begin
      n_cmp++;
      if (dut_reg(a) !== model[a]) begin
        n_bad++; $display("FAIL b2b_reg%0d got=%h exp=%h", a, dut_reg(a), model[a]);
      end
    end
    n_cmp++;
    if (strobe_cnt !== exp_strobe || err_cnt !== exp_err) begin
      n_bad++; $display("FAIL b2b_pulses strobe=%0d/%0d err=%0d/%0d", strobe_cnt, exp_strobe, err_cnt, exp_err);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] erx, rx;
    logic [15:0] f;
    model_frame(16'h813C, 16, erx);
    send_frame(16'h813C, 16, 8, 1'b1, rx);
    n_cmp++;
    if (en_reg_out_15_8 !== 8'h3C) begin
      n_bad++; $display("FAIL midrst_pre got=%h exp=3c", en_reg_out_15_8);
    end
    f = 16'h81FF;
    spi_if.ncs = 1'b0;
    clk_wait(HALF);
    for (int i = 0; i < 16; i++) begin
      spi_if.copi = f[15-i];
      if (i == 8) begin
        rst = 1'b1; clk_wait(1); rst = 1'b0;
        for (int a = 0; a < 5; a++) model[a] = 8'h00;
        clk_wait(HALF - 1);
      end else begin
        clk_wait(HALF);
      end
      spi_if.sclk = 1'b1; clk_wait(HALF); spi_if.sclk = 1'b0;
    end
    clk_wait(HALF);
    spi_if.ncs = 1'b1;
    spi_if.copi = 1'b0;
    clk_wait(10);
    for (int a = 0; a < 5; a++) begin
      n_cmp++;
      if (dut_reg(a) !== model[a]) begin
        n_bad++; $display("FAIL midrst_reg%0d got=%h exp=%h", a, dut_reg(a), model[a]);
      end
    end
    n_cmp++;
    if (strobe_cnt !== exp_strobe || err_cnt !== exp_err) begin
      n_bad++; $display("FAIL midrst_pulses strobe=%0d/%0d err=%0d/%0d", strobe_cnt, exp_strobe, err_cnt, exp_err);
    end
  endtask

`ifdef SPI_READBACK_EN
  task automatic test_readback();
    logic [31:0] erx, rx;
    model_frame(16'h835A, 16, erx);
    send_frame(16'h835A, 16, 8, 1'b1, rx);
    model_frame(16'h0300, 16, erx);
    send_frame(16'h0300, 16, 8, 1'b1, rx);
    n_cmp++;
    if (rx[15:0] !== erx[15:0] || {rx[8], rx[9], rx[10], rx[11], rx[12], rx[13], rx[14], rx[15]} !== 8'h5A) begin
      n_bad++; $display("FAIL readback_0300 got=%h exp=%h", rx[15:0], erx[15:0]);
    end
    n_cmp++;
    if (spi_if.cipo !== 1'b0) begin
      n_bad++; $display("FAIL readback_idle_cipo got=%b exp=0", spi_if.cipo);
    end
    model_frame(16'h0700, 16, erx);
    send_frame(16'h0700, 16, 8, 1'b1, rx);
    n_cmp++;
    if (rx[16:0] !== 17'h0) begin
      n_bad++; $display("FAIL readback_0700 got=%h exp=0", rx[16:0]);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] erx, rx;
    logic [15:0] f;
    int nb, r;
    for (int n = 0; n < 30; n++) begin
      f = 16'($urandom);
      f[14:8] = 7'($urandom_range(0, 7));
      r = int'($urandom_range(0, 9));
      nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      model_frame(f, nb, erx);
      send_frame(f, nb, 8, 1'b1, rx);
      for (int a = 0; a < 5; a++) begin
        n_cmp++;
        if (dut_reg(a) !== model[a]) begin
          n_bad++; $display("FAIL rand%0d_%h_%0db_reg%0d got=%h exp=%h", n, f, nb, a, dut_reg(a), model[a]);
        end
      end
      n_cmp++;
      if (strobe_cnt !== exp_strobe || err_cnt !== exp_err) begin
        n_bad++; $display("FAIL rand%0d_pulses strobe=%0d/%0d err=%0d/%0d", n, strobe_cnt, exp_strobe, err_cnt, exp_err);
      end
      if (nb == 16) begin
        n_cmp++;
        if (rx[15:0] !== erx[15:0]) begin
          n_bad++; $display("FAIL rand%0d_cipo got=%h exp=%h", n, rx[15:0], erx[15:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_bad_length();
    test_latency();
    test_back_to_back();
    test_reset_midframe();
`ifdef SPI_READBACK_EN
    test_readback();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
SPI target (mode 0) that receives 16-bit write frames from an off-chip controller and holds the five PWM control registers. It sits directly upstream of pwm_peripheral in the tile top and drives its en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle inputs. SPI pins are asynchronous to clk and are oversampled through synchronizers.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each SPI input synchronizer (minimum 2)
MAX_ADDR, 4, highest valid register address; frames addressed above this are ignored

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sclk  input  1  SPI clock, asynchronous
copi  input  1  SPI controller-out data, asynchronous
ncs  input  1  SPI chip select, active-low, asynchronous
cipo  output  1  SPI target-out data; constant 0 unless SPI_READBACK_EN is defined
en_reg_out_7_0  output  8  register at address 0x00
en_reg_out_15_8  output  8  register at address 0x01
en_reg_pwm_7_0  output  8  register at address 0x02
en_reg_pwm_15_8  output  8  register at address 0x03
pwm_duty_cycle  output  8  register at address 0x04
wr_strobe  output  1  one-clk pulse when a register is updated
err_frame  output  1  one-clk pulse when a frame ends with a bit count other than 16

Behaviour:
- Interface decision: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: all five registers are 0x00. wr_strobe, err_frame and cipo are 0. The bit counter and shift register are cleared. Synchronizer stages load ncs=1 and sclk=0.
- Synchronization: sclk, copi and ncs each pass through SYNC_STAGES flops. One extra flop on sclk and on ncs provides edge detection.
- SCLK constraint: the high and low phases must each last at least SYNC_STAGES+1 clk periods. Faster SCLK is undefined.
- States: IDLE, SHIFT, COMMIT.
- IDLE -> SHIFT on the synchronized ncs falling edge. Counter and shift register clear on entry.
- SHIFT: on each synchronized sclk rising edge, shift copi into bit 0 of a 16-bit shift register (MSB first).
- Counter: the bit counter increments and saturates at 17. A value of 17 marks an overlength frame.
- Frame format: bit15 = R/W (1 = write), bits14:8 = address (7 bits), bits7:0 = data.
- SHIFT -> COMMIT on the synchronized ncs rising edge.
- COMMIT lasts one clk, then returns to IDLE.
- Valid write: count==16, R/W=1 and address<=MAX_ADDR. In COMMIT the addressed register loads data and wr_strobe pulses in the same clk. The register output changes SYNC_STAGES+2 clk after the raw ncs rise.
- Address above MAX_ADDR: no register change, no wr_strobe, no err_frame.
- Read frame (R/W=0): no register change, no wr_strobe.
- Bad length (count!=16, including 0 and 17): no register change, and err_frame pulses in COMMIT.
- Simultaneous events: a synchronized sclk rising edge in the same clk as the ncs rising edge is ignored, and the ncs edge wins. sclk edges while ncs is high are ignored.
- Reset mid-frame: the frame is abandoned and registers return to 0x00. A new ncs falling edge is required before any bits are captured, so an ncs rise with no preceding fall does nothing.
- Registers hold their value indefinitely between frames. Back-to-back frames need only ncs high for SYNC_STAGES+2 clk.

Optional Feature:
SPI_READBACK_EN
- Defined: a read frame (R/W=0) returns register data on cipo.
  - After the 8th sclk rising edge, the addressed register is latched. Address above MAX_ADDR returns 0x00.
  - cipo presents data bit 7 on the next synchronized sclk falling edge. Each later falling edge shifts out the next bit, MSB first, for bits 7..0.
  - cipo is 0 during the address phase, while ncs is high, and after the last bit.
  - Write frames keep cipo at 0.
- Undefined: cipo is tied to 0 and read frames are no-ops.

Test Plan:
1. Assert rst for 3 clk, then release -> all five registers 0x00, wr_strobe=0, err_frame=0, cipo=0.
2. Frame 0x80F0 (write, addr 0x00, data 0xF0), SCLK = clk/8 -> en_reg_out_7_0=0xF0, single wr_strobe pulse, other registers 0x00.
3. Frames 0x8480 then 0x82FF -> pwm_duty_cycle=0x80, en_reg_pwm_7_0=0xFF, two wr_strobe pulses. Then frame 0x85AA (addr 0x05) -> no change, no strobe, no err_frame.
4. 15-bit frame and 17-bit frame, each aimed at addr 0x01 -> en_reg_out_15_8 stays 0x00, one err_frame pulse per frame, no wr_strobe.
5. Write 0x813C, then raise rst for 1 clk midway through a following 0x81FF frame, then pulse ncs high -> en_reg_out_15_8=0x00, no strobe after reset.
6. (SPI_READBACK_EN) Write 0x835A, then read frame 0x0300 -> cipo bits 8..15 = 0,1,0,1,1,0,1,0. Read frame 0x0700 -> cipo all 0.
